// File: rtl/wm_beat_packer_pkg.sv
// ============================================================================
// Module : lib_pkg
// Brief  : Shared types and helpers for the write-side beat packer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lib_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned MASK_MAX = 64;

    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    // Contiguous run of `count` ones starting at bit `offset`
    function automatic logic [MASK_MAX-1:0] lane_mask(input int unsigned count,
                                                      input int unsigned offset);
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_MAX; i++) begin
            if (i >= offset && i < offset + count) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wm_beat_packer_if.sv
// ============================================================================
// Module : wm_beat_packer_if
// Brief  : Command, input-beat and output-beat channels of the beat packer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface wm_beat_packer_if #(
    parameter int EW   = 8,
    parameter int IBEC = 16,
    parameter int OBEC = 16,
    parameter int LENW = 16
);
    localparam int OOFSW = (OBEC == 1) ? 1 : $clog2(OBEC);

    logic               cmd_val;
    logic               cmd_rdy;
    logic [OOFSW-1:0]   cmd_ofs;
    logic [LENW-1:0]    cmd_len;
    logic               ival;
    logic               irdy;
    logic [IBEC*EW-1:0] ib;
    logic               oval;
    logic               ordy;
    logic [OBEC*EW-1:0] ob;
    logic [OBEC-1:0]    ostrb;
    logic               olast;
    logic               busy;

    modport master (
        output cmd_val, cmd_ofs, cmd_len, ival, ib, ordy,
        input  cmd_rdy, irdy, oval, ob, ostrb, olast, busy
    );

    modport slave (
        input  cmd_val, cmd_ofs, cmd_len, ival, ib, ordy,
        output cmd_rdy, irdy, oval, ob, ostrb, olast, busy
    );

endinterface

`default_nettype wire

// File: rtl/wm_beat_packer_elem_buf.sv
// ============================================================================
// Module : wm_elem_buf
// Brief  : Circular element buffer with variable push/pop counts and a
//          read window of OBEC elements starting at the read pointer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wm_elem_buf #(
    parameter int EW     = 8,
    parameter int IBEC   = 16,
    parameter int OBEC   = 16,
    parameter int BUFEC  = IBEC + OBEC,
    parameter int BUFECW = $clog2(BUFEC + 1)
) (
    input  wire logic               clk,
    input  wire logic               rstn,
    input  wire logic               clr,
    input  wire logic               push_en,
    input  wire logic [BUFECW-1:0]  push_n,
    input  wire logic [IBEC*EW-1:0] push_data,
    input  wire logic               pop_en,
    input  wire logic [BUFECW-1:0]  pop_n,
    output logic      [OBEC*EW-1:0] win,
    output logic      [BUFECW-1:0]  avail
);
    localparam int PW = BUFECW + 1;
    localparam int AW = (BUFEC > 1) ? $clog2(BUFEC) : 1;

    logic [EW-1:0]     r_mem [BUFEC];
    logic [BUFECW-1:0] r_wptr;
    logic [BUFECW-1:0] r_rptr;
    logic [BUFECW-1:0] r_avail;
    logic [PW-1:0]     w_avail_nxt;

    // Operands are always below 2*BUFEC, so one conditional subtract wraps
    function automatic logic [BUFECW-1:0] wrap(input logic [PW-1:0] idx);
        return (idx >= PW'(BUFEC)) ? BUFECW'(idx - PW'(BUFEC)) : BUFECW'(idx);
    endfunction

    assign w_avail_nxt = PW'(r_avail)
                       + (push_en ? PW'(push_n) : PW'(0))
                       - (pop_en  ? PW'(pop_n)  : PW'(0));
    assign avail = r_avail;

    always_comb begin
        win = '0;
        for (int k = 0; k < OBEC; k++) begin
            win[k*EW +: EW] = r_mem[AW'(wrap(PW'(r_rptr) + PW'(k)))];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_avail <= '0;
            for (int i = 0; i < BUFEC; i++) r_mem[i] <= '0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_avail <= '0;
        end else begin
            if (push_en) begin
                for (int i = 0; i < IBEC; i++) begin
                    if (BUFECW'(i) < push_n)
                        r_mem[AW'(wrap(PW'(r_wptr) + PW'(i)))] <= push_data[i*EW +: EW];
                end
                r_wptr <= wrap(PW'(r_wptr) + PW'(push_n));
            end
            if (pop_en) r_rptr <= wrap(PW'(r_rptr) + PW'(pop_n));
            r_avail <= BUFECW'(w_avail_nxt);
        end
    end

endmodule

`default_nettype wire

// File: rtl/wm_beat_packer.sv
// ============================================================================
// Module : wm_beat_packer
// Brief  : Packs dense input beats into offset-aligned, strobed output beats
//          for an AXI-style write-data channel.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wm_beat_packer
    import lib_pkg::*;
#(
    parameter int EW    = 8,
    parameter int IBEC  = 16,
    parameter int OBEC  = 16,
    parameter int BUFEC = IBEC + OBEC,
    parameter int LENW  = 16
) (
    input  wire logic          clk,
    input  wire logic          rstn,
    wm_beat_packer_if.slave    bus
);
    localparam int OOFSW  = (OBEC == 1) ? 1 : $clog2(OBEC);
    localparam int OBECW  = $clog2(OBEC + 1);
    localparam int BUFECW = $clog2(BUFEC + 1);

    state_t             r_state;
    logic [LENW-1:0]    r_rem_in;
    logic [LENW-1:0]    r_rem_out;
    logic [OOFSW-1:0]   r_cur_ofs;

    logic               w_run;
    logic               w_irdy;
    logic               w_oval;
    logic               w_push;
    logic               w_pop;
    logic               w_clr;
    logic               w_last;
    logic [BUFECW-1:0]  w_push_n;
    logic [BUFECW-1:0]  w_avail;
    logic [OBECW-1:0]   w_cur_n;
    logic [OBEC*EW-1:0] w_win;
    logic [OBEC*EW-1:0] w_ob;
    logic [OBEC-1:0]    w_strb;

    assign w_run    = (r_state == RUN);
    assign w_push_n = BUFECW'(umin(IBEC, 32'(r_rem_in)));
    assign w_cur_n  = OBECW'(umin(OBEC - 32'(r_cur_ofs), 32'(r_rem_out)));

    assign w_irdy = w_run && (r_rem_in != '0) && ((BUFECW'(BUFEC) - w_avail) >= w_push_n);
    assign w_oval = w_run && (32'(w_avail) >= 32'(w_cur_n));
    assign w_last = w_oval && (32'(r_rem_out) == 32'(w_cur_n));
    assign w_push = bus.ival && w_irdy;
    assign w_pop  = w_oval && bus.ordy;
    assign w_clr  = !w_run && bus.cmd_val && (bus.cmd_len != '0);

    wm_elem_buf #(
        .EW     (EW),
        .IBEC   (IBEC),
        .OBEC   (OBEC),
        .BUFEC  (BUFEC),
        .BUFECW (BUFECW)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (w_clr),
        .push_en   (w_push),
        .push_n    (w_push_n),
        .push_data (bus.ib),
        .pop_en    (w_pop),
        .pop_n     (BUFECW'(w_cur_n)),
        .win       (w_win),
        .avail     (w_avail)
    );

    assign w_strb = w_run ? OBEC'(lane_mask(32'(w_cur_n), 32'(r_cur_ofs))) : '0;

    // Window element k lands on lane cur_ofs+k; unstrobed lanes stay zero
    always_comb begin
        w_ob = '0;
        for (int j = 0; j < OBEC; j++) begin
            if (w_strb[j]) w_ob[j*EW +: EW] = w_win[(j - int'(r_cur_ofs))*EW +: EW];
        end
    end

    assign bus.cmd_rdy = !w_run;
    assign bus.busy    = w_run;
    assign bus.irdy    = w_irdy;
    assign bus.oval    = w_oval;
    assign bus.ob      = w_ob;
    assign bus.ostrb   = w_strb;
    assign bus.olast   = w_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_rem_in  <= '0;
            r_rem_out <= '0;
            r_cur_ofs <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_val && bus.cmd_len != '0) begin
                        r_rem_in  <= bus.cmd_len;
                        r_rem_out <= bus.cmd_len;
                        r_cur_ofs <= bus.cmd_ofs;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (w_push) r_rem_in <= r_rem_in - LENW'(w_push_n);
                    if (w_pop) begin
                        r_rem_out <= r_rem_out - LENW'(w_cur_n);
                        r_cur_ofs <= '0;
                        if (w_last) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wm_beat_packer.sv
// ============================================================================
// Module : tb_wm_beat_packer
// Brief  : Self-checking bench; expected beats come from element positions.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_wm_beat_packer;
    localparam int EW    = 8;
    localparam int IBEC  = 4;
    localparam int OBEC  = 4;
    localparam int LENW  = 16;
    localparam int BUFEC = IBEC + OBEC;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    wm_beat_packer_if #(.EW(EW), .IBEC(IBEC), .OBEC(OBEC), .LENW(LENW)) bus ();

    wm_beat_packer #(
        .EW    (EW),
        .IBEC  (IBEC),
        .OBEC  (OBEC),
        .BUFEC (BUFEC),
        .LENW  (LENW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [EW-1:0]      elem   [256];
    logic [OBEC*EW-1:0] exp_ob [64];
    logic [OBEC-1:0]    exp_st [64];
    int                 bn     [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".cmd_rdy"}, 64'(bus.cmd_rdy), 64'd1);
        chk({tag, ".irdy"},    64'(bus.irdy),    64'd0);
        chk({tag, ".oval"},    64'(bus.oval),    64'd0);
        chk({tag, ".ob"},      64'(bus.ob),      64'd0);
        chk({tag, ".ostrb"},   64'(bus.ostrb),   64'd0);
        chk({tag, ".olast"},   64'(bus.olast),   64'd0);
        chk({tag, ".busy"},    64'(bus.busy),    64'd0);
    endtask

    // Entered and left at posedge+1. imode/omode: 0 = always on, 1 = random,
    // omode 2 = ordy held low for the first 10 cycles.
    task automatic run_burst(input int ofs, input int len, input int imode,
                             input int omode, input bit abort, input bit directed);
        int nb, in_cnt, out_cnt, bi, occ, push, left, p;
        bit e_irdy, e_oval, acc_out;

        for (int i = 0; i < len; i++) elem[i] = directed ? 8'(8'hA0 + i) : 8'($urandom);
        for (int b = 0; b < 64; b++) begin
            exp_ob[b] = '0;
            exp_st[b] = '0;
            bn[b]     = 0;
        end
        for (int i = 0; i < len; i++) begin
            p = ofs + i;
            exp_ob[p / OBEC][(p % OBEC)*EW +: EW] = elem[i];
            exp_st[p / OBEC][p % OBEC] = 1'b1;
            bn[p / OBEC]++;
        end
        nb = (ofs + len + OBEC - 1) / OBEC;

        bus.cmd_val = 1'b1;
        bus.cmd_ofs = 2'(ofs);
        bus.cmd_len = 16'(len);
        #3;
        chk("cmd_rdy_before", 64'(bus.cmd_rdy), 64'd1);
        @(posedge clk); #1;
        bus.cmd_val = 1'b0;

        in_cnt = 0;
        out_cnt = 0;
        bi = 0;
        for (int cyc = 0; cyc < 500 && bi < nb; cyc++) begin
            left = len - in_cnt;
            bus.ival = (left > 0) && (imode == 0 || $urandom_range(0, 2) != 0);
            for (int l = 0; l < IBEC; l++)
                bus.ib[l*EW +: EW] = (l < left) ? elem[in_cnt + l] : 8'($urandom);
            case (omode)
                0:       bus.ordy = 1'b1;
                1:       bus.ordy = ($urandom_range(0, 2) != 0);
                default: bus.ordy = (cyc >= 10);
            endcase
            #3;
            occ    = in_cnt - out_cnt;
            push   = (left < IBEC) ? left : IBEC;
            e_irdy = (left > 0) && (BUFEC - occ >= push);
            e_oval = (occ >= bn[bi]);
            chk("irdy",    64'(bus.irdy),    64'(e_irdy));
            chk("oval",    64'(bus.oval),    64'(e_oval));
            chk("busy",    64'(bus.busy),    64'd1);
            chk("cmd_rdy", 64'(bus.cmd_rdy), 64'd0);
            if (e_oval && bus.oval === 1'b1) begin
                chk("ob",    64'(bus.ob),    64'(exp_ob[bi]));
                chk("ostrb", 64'(bus.ostrb), 64'(exp_st[bi]));
                chk("olast", 64'(bus.olast), 64'(bi == nb - 1));
            end
            acc_out = e_oval && bus.ordy;
            if (bus.ival && e_irdy) in_cnt += push;
            if (acc_out) begin
                out_cnt += bn[bi];
                bi++;
            end
            @(posedge clk); #1;
            if (acc_out && abort) begin
                rstn     = 1'b0;
                bus.ival = 1'b0;
                bus.ordy = 1'b0;
                #3;
                check_idle("abort");
                @(posedge clk); #1;
                rstn = 1'b1;
                return;
            end
        end
        bus.ival = 1'b0;
        bus.ordy = 1'b0;
        chk("beats_done", 64'(bi), 64'(nb));
        #3;
        chk("post.cmd_rdy", 64'(bus.cmd_rdy), 64'd1);
        chk("post.busy",    64'(bus.busy),    64'd0);
        chk("post.oval",    64'(bus.oval),    64'd0);
        chk("post.irdy",    64'(bus.irdy),    64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.cmd_val = 1'b0;
        bus.cmd_ofs = '0;
        bus.cmd_len = '0;
        bus.ival    = 1'b0;
        bus.ib      = '0;
        bus.ordy    = 1'b0;
        rstn        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        run_burst(1, 6, 0, 0, 1'b0, 1'b1);
        run_burst(0, 8, 0, 0, 1'b0, 1'b1);
        run_burst(3, 1, 0, 0, 1'b0, 1'b1);
        run_burst(0, 16, 0, 2, 1'b0, 1'b1);

        // Zero-length command is swallowed without starting a burst
        bus.cmd_val = 1'b1;
        bus.cmd_ofs = '0;
        bus.cmd_len = '0;
        #3;
        chk("len0.cmd_rdy", 64'(bus.cmd_rdy), 64'd1);
        @(posedge clk); #1;
        bus.cmd_val = 1'b0;
        repeat (3) begin
            #3;
            chk("len0.oval",    64'(bus.oval),    64'd0);
            chk("len0.busy",    64'(bus.busy),    64'd0);
            chk("len0.cmd_rdy", 64'(bus.cmd_rdy), 64'd1);
            @(posedge clk); #1;
        end
        run_burst(0, 4, 0, 0, 1'b0, 1'b1);

        run_burst(0, 8, 0, 0, 1'b1, 1'b1);
        run_burst(2, 2, 0, 0, 1'b0, 1'b1);

        for (int t = 0; t < 25; t++)
            run_burst(int'($urandom_range(0, 3)), int'($urandom_range(1, 40)), 1, 1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
